// File: rtl/spi_reg_bridge.sv
// Purpose : SPI mode-0 write-only slave; turns serial frames into single-byte
//           register writes (we/addr/data_out) with burst address auto-increment.
// Latency : we rises on the 4th clk edge after the raw sclk edge carrying bit 8
//           (2 sync + 1 edge detect + 1 output register).
// Backpressure: none; reg_map must accept one write per strobe, and the
//           cs_n/sclk/mosi synchronisers assume clk >= 8x sclk.
//
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   sclk, cs_n, mosi  raw SPI inputs from the host (asynchronous to clk)
//   we, addr, data_out  one-cycle register write strobe with its address/data
//   busy            frame in progress (synchronised cs_n low)
//   err             sticky frame error, cleared when the next frame starts
module spi_reg_bridge #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 31,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_t;

  // Synchroniser, delay and edge-detect stages
  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2, mosi_d;
  logic sclk_rise_q, cs_rise_q, cs_fall_q;
  logic [1:0] settle_cnt;
  logic armed;

  // A cs_n fall is only honoured after cs_n has been seen high once the
  // synchronisers have flushed their reset values. This keeps a host that
  // holds cs_n low through a reset from starting a half-received frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1     <= 1'b0;
      sclk_s2     <= 1'b0;
      sclk_d      <= 1'b0;
      cs_s1       <= 1'b1;
      cs_s2       <= 1'b1;
      cs_d        <= 1'b1;
      mosi_s1     <= 1'b0;
      mosi_s2     <= 1'b0;
      mosi_d      <= 1'b0;
      sclk_rise_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      settle_cnt  <= 2'd0;
      armed       <= 1'b0;
    end else begin
      sclk_s1     <= sclk;
      sclk_s2     <= sclk_s1;
      sclk_d      <= sclk_s2;
      cs_s1       <= cs_n;
      cs_s2       <= cs_s1;
      cs_d        <= cs_s2;
      mosi_s1     <= mosi;
      mosi_s2     <= mosi_s1;
      mosi_d      <= mosi_s2;
      // mosi_d lines up with sclk_rise_q, so the bit sampled is the one
      // present at the synchronised rising edge.
      sclk_rise_q <= sclk_s2 & ~sclk_d;
      cs_rise_q   <= cs_s2 & ~cs_d;
      cs_fall_q   <= ~cs_s2 & cs_d & armed;
      if (settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else if (cs_s2 && cs_d) begin
        armed <= 1'b1;
      end
    end
  end

  state_t                state;
  logic [2:0]            bit_cnt;
  logic [DATA_WIDTH-2:0] shreg;
  logic [ADDR_WIDTH-1:0] addr_ptr;

  logic [DATA_WIDTH-1:0] new_byte;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic                  cmd_ok;
  logic                  partial_pending;

  assign new_byte = {shreg, mosi_d};
  assign cmd_addr = new_byte[ADDR_WIDTH-1:0];
  assign cmd_ok   = new_byte[7] &&
                    ({{(32-ADDR_WIDTH){1'b0}}, cmd_addr} < NUM_REGS);
  // Bits left over once any same-cycle sclk edge has been counted
  assign partial_pending = sclk_rise_q ? (bit_cnt != 3'd7) : (bit_cnt != 3'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shreg    <= '0;
      addr_ptr <= '0;
      we       <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall_q) begin
            state   <= CMD;
            busy    <= 1'b1;
            err     <= 1'b0;
            bit_cnt <= 3'd0;
          end
        end
        CMD, DATA: begin
          if (sclk_rise_q) begin
            shreg   <= new_byte[DATA_WIDTH-2:0];
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == CMD) begin
                if (cmd_ok) begin
                  addr_ptr <= cmd_addr;
                  state    <= DATA;
                end else begin
                  err   <= 1'b1;
                  state <= IGNORE;
                end
              end else begin
                we       <= 1'b1;
                addr     <= addr_ptr;
                data_out <= new_byte;
                // No wrap-around: writing the last register ends the burst
                if (addr_ptr == LAST_ADDR) begin
                  err   <= 1'b1;
                  state <= IGNORE;
                end else begin
                  addr_ptr <= addr_ptr + 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase

      // End of frame takes priority over the state update above, but a byte
      // completed in the same cycle has already issued its write.
      if (cs_rise_q && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        bit_cnt <= 3'd0;
        if (state == DATA && partial_pending) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave front-end (mode 0, write-only) that converts serial frames from the host MCU into single-byte register writes (we/addr/data) for reg_map, which sits directly downstream.
- Supports burst writes with address auto-increment, so one frame can load a full 24-bit band gain (3 bytes) or the whole 31-byte register bank.
- Contains SCLK/CS_N/MOSI synchronisers, a bit counter, a frame FSM and address range checking.

Parameters:
ADDR_WIDTH, 5, width of the register address driven to reg_map
NUM_REGS, 31, number of valid registers (addresses 0..NUM_REGS-1)
DATA_WIDTH, 8, register data width; fixed at 8 and not overridden

Ports:
clk  input  1  system clock; must be at least 8x the sclk frequency
rst  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from host, asynchronous to clk
cs_n  input  1  SPI chip select, active low, asynchronous
mosi  input  1  SPI data in, MSB first
we  output  1  register write strobe, exactly one clk cycle wide per byte
addr  output  ADDR_WIDTH  register address for the current write
data_out  output  DATA_WIDTH  register data for the current write (connects to reg_map data_in)
busy  output  1  high while a frame is active (synchronised cs_n low)
err  output  1  sticky frame error; cleared at the start of the next frame

Behaviour:
- Reset (rst=0, async): we=0, addr=0, data_out=0, busy=0, err=0, state IDLE, bit_cnt=0. Synchroniser flops reset to sclk=0, cs_n=1, mosi=0.
- Synchronisation: 2-FF synchronisers on sclk, cs_n and mosi, followed by one registered stage for edge detection. All decisions use the synchronised signals only.
- SPI mode 0: mosi is sampled on each synchronised sclk rising edge and shifted into an 8-bit register, MSB first. Falling edges are ignored.
- FSM states:
  - IDLE: wait for a synchronised cs_n falling edge. On the edge: go to CMD, set busy=1, clear err, clear bit_cnt.
  - CMD: collect 8 bits into the command byte.
    - Bit7 = 1 (write) and bits[4:0] < NUM_REGS: load addr_ptr = bits[4:0], go to DATA.
    - Otherwise (bit7 = 0, or address >= NUM_REGS): set err=1, go to IGNORE.
    - Bits[6:5] are don't-care.
  - DATA: each completed byte produces one write:
    - Drive we=1 for one cycle, with addr=addr_ptr and data_out=byte.
    - If addr_ptr == NUM_REGS-1: set err=1 and go to IGNORE (no wrap-around).
    - Otherwise: addr_ptr += 1 and stay in DATA.
  - IGNORE: discard all sclk activity until cs_n rises.
- cs_n rising edge (synchronised), from any state:
  - Go to IDLE and set busy=0.
  - A partially received byte (bit_cnt != 0) is discarded, produces no we, and sets err=1 only if the state was DATA.
  - A frame with only a partial command byte leaves err=0.
- Latency: we rises on the 4th clk rising edge after the raw sclk rising edge that carries the 8th bit of a data byte (2 sync + 1 edge + 1 output register). The bench accepts 4 cycles of latency exactly.
- addr and data_out hold their last written values between strobes and when idle. They are updated only in the same cycle as we=1.
- we is never asserted outside DATA, never for more than one cycle per byte, and never for a byte completed after cs_n has risen.
- Simultaneous events: if the sclk edge completing a byte and the cs_n rise are detected in the same clk cycle, the byte completes and its write is issued; the cs_n rise then takes effect.
- Reset mid-frame: all state clears. If cs_n is still low when rst releases, no falling edge is seen; the block stays IDLE (busy=0) until cs_n goes high and then low again.
- busy follows the synchronised cs_n, with 2-3 cycles of delay.

Test Plan:
- Single burst: cs_n low, bytes 0x81, 0xA0, 0xFE, 0xFF, cs_n high -> three we pulses: (addr 1, 0xA0), (addr 2, 0xFE), (addr 3, 0xFF); err=0. reg_map gain_1 = 0xFFFEA0.
- Full bank: cmd 0x80 followed by 31 bytes 0x00..0x1E -> 31 we pulses, addr n with data n. Then 1 extra byte -> no 32nd pulse, err=1.
- Invalid command: cmd 0x1F (read) or 0x9F (addr 31) then byte 0x55 -> no we, err=1. The next valid frame 0x80, 0xAA -> err clears at cs_n fall; we with addr 0, data 0xAA.
- Aborted byte: cmd 0x8A, 0x11, then 5 bits, then cs_n high -> one we (addr 10, 0x11), no second pulse, err=1, busy=0.
- Latency/width check: measure we rise at exactly 4 clk cycles after the 8th sclk rise; we width = 1 cycle; sclk at clk/8 and clk/16 both pass.
- Reset mid-frame: assert rst after cmd 0x84 and 4 data bits, release with cs_n low, clock 8 more bits -> no we, busy=0. After cs_n high and a new frame 0x84, 0x06 -> we with addr 4, data 0x06.
